// File: rtl/integer_issue_scheduler.sv
// Issue-side scheduler for the integer execution unit: writeback slot reservation,
// divider serialisation and MUL/DIV/BMU clock-enable generation with idle timeout.
module integer_issue_scheduler #(
    parameter int MUL_LATENCY  = 4,
    parameter int DIV_LATENCY  = 34,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stall_i,
    input  logic       issue_valid_i,
    input  logic [1:0] issue_unit_i,
    output logic       issue_ready_o,
    output logic [3:0] data_valid_o,
    input  logic       div_idle_i,
    input  logic       div_valid_i,
    input  logic       result_valid_i,
    output logic       mul_clk_en_o,
    output logic       div_clk_en_o,
    output logic       bmu_clk_en_o
);

    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);
    localparam int CNT_W   = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_BMU = 2'd1,
        UNIT_MUL = 2'd2,
        UNIT_DIV = 2'd3
    } unit_e;

    unit_e                  unit;
    logic [LAT_W-1:0]       lat;
    logic [MAX_LAT:0]       rsv;
    logic [MAX_LAT:0]       rsv_set;
    logic [MUL_LATENCY-1:0] mul_pipe;
    logic                   bmu_inflight;
    logic                   div_busy;
    logic                   div_ok;
    logic                   issue;
    logic [2:0]             unit_issue;   // {DIV, MUL, BMU}
    logic [2:0]             inflight;
    logic [2:0]             clk_en;
    logic [CNT_W-1:0]       cnt [3];

    assign unit = unit_e'(issue_unit_i);

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lat = '0;
        case (unit)
            UNIT_ALU: lat = '0;
            UNIT_BMU: lat = LAT_W'(1);
            UNIT_MUL: lat = LAT_W'(MUL_LATENCY);
            UNIT_DIV: lat = LAT_W'(DIV_LATENCY);
            default:  lat = '0;
        endcase
    end

    assign div_ok        = (unit != UNIT_DIV) || (!div_busy && div_idle_i);
    assign issue_ready_o = !rst_i && !stall_i && !rsv[lat] && div_ok;
    assign issue         = issue_valid_i && issue_ready_o;

    always_comb begin
        data_valid_o = '0;
        rsv_set      = '0;
        if (issue) begin
            data_valid_o[issue_unit_i] = 1'b1;
            // The slot is claimed one position early because the vector shifts on this same edge.
            if (unit != UNIT_ALU) rsv_set[lat - LAT_W'(1)] = 1'b1;
        end
    end

    assign unit_issue = data_valid_o[3:1];
    assign inflight   = {div_busy, |mul_pipe, bmu_inflight};

    always_comb begin
        clk_en = '0;
        for (int i = 0; i < 3; i++)
            clk_en[i] = !rst_i && (unit_issue[i] || inflight[i] || (cnt[i] != '0));
    end

    assign {div_clk_en_o, mul_clk_en_o, bmu_clk_en_o} = clk_en;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsv          <= '0;
            mul_pipe     <= '0;
            bmu_inflight <= 1'b0;
            div_busy     <= 1'b0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else if (!stall_i) begin
            rsv          <= (rsv >> 1) | rsv_set;
            mul_pipe     <= {data_valid_o[UNIT_MUL], mul_pipe[MUL_LATENCY-1:1]};
            bmu_inflight <= data_valid_o[UNIT_BMU];
            if (data_valid_o[UNIT_DIV])
                div_busy <= 1'b1;
            else if (div_valid_i)
                div_busy <= 1'b0;
            // Idle countdown only starts once the unit has drained.
            for (int i = 0; i < 3; i++) begin
                if (unit_issue[i])
                    cnt[i] <= CNT_W'(IDLE_TIMEOUT);
                else if ((cnt[i] != '0) && !inflight[i])
                    cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    // Simulation-only consistency checks against the integer unit's responses.
    logic [LAT_W-1:0] div_age;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_age <= '0;
        end else if (!stall_i) begin
            if (data_valid_o[UNIT_DIV])
                div_age <= LAT_W'(1);
            else if (div_busy && (div_age != LAT_W'(DIV_LATENCY)))
                div_age <= div_age + LAT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !stall_i) begin
            assert (result_valid_i == (rsv[0] | data_valid_o[UNIT_ALU]));
            assert (div_valid_i == (div_busy && (div_age == LAT_W'(DIV_LATENCY))));
            assert ($onehot0(data_valid_o));
        end
    end
`endif

endmodule

// File: tb/tb_integer_issue_scheduler.sv
// Self-checking bench for integer_issue_scheduler: per-cycle expected outputs are queued
// as stimulus is driven and compared when the cycle's outputs settle.
module tb_integer_issue_scheduler;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 34;
    localparam int IDLE    = 8;

    localparam logic [1:0] U_ALU = 2'd0;
    localparam logic [1:0] U_BMU = 2'd1;
    localparam logic [1:0] U_MUL = 2'd2;
    localparam logic [1:0] U_DIV = 2'd3;

    typedef struct packed {
        logic       ready;
        logic [3:0] dv;
        logic [2:0] en;   // {div, mul, bmu}
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       stall_i = 1'b0;
    logic       issue_valid_i = 1'b0;
    logic [1:0] issue_unit_i = 2'd0;
    logic       issue_ready_o;
    logic [3:0] data_valid_o;
    logic       div_idle_i;
    logic       div_valid_i;
    logic       result_valid_i;
    logic       mul_clk_en_o;
    logic       div_clk_en_o;
    logic       bmu_clk_en_o;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    integer_issue_scheduler #(
        .MUL_LATENCY (MUL_LAT),
        .DIV_LATENCY (DIV_LAT),
        .IDLE_TIMEOUT(IDLE)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .issue_valid_i (issue_valid_i),
        .issue_unit_i  (issue_unit_i),
        .issue_ready_o (issue_ready_o),
        .data_valid_o  (data_valid_o),
        .div_idle_i    (div_idle_i),
        .div_valid_i   (div_valid_i),
        .result_valid_i(result_valid_i),
        .mul_clk_en_o  (mul_clk_en_o),
        .div_clk_en_o  (div_clk_en_o),
        .bmu_clk_en_o  (bmu_clk_en_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural integer unit: returns results at the unit latencies and freezes on stall.
    logic [63:0] env_pend;
    int          env_div;

    always @(posedge clk_i) begin
        if (rst_i) begin
            env_pend <= '0;
            env_div  <= 0;
        end else if (!stall_i) begin
            env_pend <= (env_pend >> 1)
                      | (data_valid_o[1] ? 64'd1 : 64'd0)
                      | (data_valid_o[2] ? (64'd1 << (MUL_LAT - 1)) : 64'd0)
                      | (data_valid_o[3] ? (64'd1 << (DIV_LAT - 1)) : 64'd0);
            if (data_valid_o[3])
                env_div <= DIV_LAT;
            else if (env_div != 0)
                env_div <= env_div - 1;
        end
    end

    assign div_valid_i    = (env_div == 1);
    assign div_idle_i     = (env_div == 0);
    assign result_valid_i = env_pend[0] | data_valid_o[0];

    function automatic exp_t mk(input logic r, input logic [3:0] d, input logic [2:0] e);
        exp_t x;
        x.ready = r;
        x.dv    = d;
        x.en    = e;
        return x;
    endfunction

    task automatic apply(input logic v, input logic [1:0] u, input logic st, input logic r);
        @(posedge clk_i);
        #1;
        issue_valid_i = v;
        issue_unit_i  = u;
        stall_i       = st;
        rst_i         = r;
        #4;
    endtask

    function automatic exp_t observed();
        exp_t x;
        x.ready = issue_ready_o;
        x.dv    = data_valid_o;
        x.en    = {div_clk_en_o, mul_clk_en_o, bmu_clk_en_o};
        return x;
    endfunction

    task automatic test_reset();
        exp_t e, got;
        for (int t = 0; t < 3; t++) begin
            exp_q.push_back((t < 2) ? mk(1'b0, 4'b0000, 3'b000) : mk(1'b1, 4'b0001, 3'b000));
            apply(1'b1, U_ALU, 1'b0, t < 2);
            got = observed();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset t=%0d: got ready=%b dv=%b en=%b, required ready=%b dv=%b en=%b",
                         t, got.ready, got.dv, got.en, e.ready, e.dv, e.en);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, got;
        for (int t = -1; t <= 10; t++) begin
            if (t < 0)       exp_q.push_back(mk(1'b0, 4'b0000, 3'b000));
            else if (t < 10) exp_q.push_back(mk(1'b1, 4'b0001, 3'b000));
            else             exp_q.push_back(mk(1'b1, 4'b0000, 3'b000));
            apply((t >= 0) && (t < 10), U_ALU, 1'b0, t < 0);
            got = observed();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL alu_b2b t=%0d: got ready=%b dv=%b en=%b, required ready=%b dv=%b en=%b",
                         t, got.ready, got.dv, got.en, e.ready, e.dv, e.en);
            end
        end
    endtask

    task automatic test_mul_slot();
        exp_t e, got;
        logic v;
        logic [1:0] u;
        for (int t = -1; t <= 5; t++) begin
            v = (t == 0) || (t >= 4);
            u = (t == 0) ? U_MUL : U_ALU;
            case (t)
                -1:      exp_q.push_back(mk(1'b0, 4'b0000, 3'b000));
                0:       exp_q.push_back(mk(1'b1, 4'b0100, 3'b010));
                4:       exp_q.push_back(mk(1'b0, 4'b0000, 3'b010));
                5:       exp_q.push_back(mk(1'b1, 4'b0001, 3'b010));
                default: exp_q.push_back(mk(1'b1, 4'b0000, 3'b010));
            endcase
            apply(v, u, 1'b0, t < 0);
            got = observed();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL mul_slot t=%0d: got ready=%b dv=%b en=%b, required ready=%b dv=%b en=%b",
                         t, got.ready, got.dv, got.en, e.ready, e.dv, e.en);
            end
        end
    endtask

    task automatic test_bmu_slot();
        exp_t e, got;
        logic v;
        logic [1:0] u;
        for (int t = -1; t <= 5; t++) begin
            v = (t == 0) || (t >= 3);
            u = (t == 0) ? U_MUL : ((t == 5) ? U_ALU : U_BMU);
            case (t)
                -1:      exp_q.push_back(mk(1'b0, 4'b0000, 3'b000));
                0:       exp_q.push_back(mk(1'b1, 4'b0100, 3'b010));
                3:       exp_q.push_back(mk(1'b0, 4'b0000, 3'b010));
                4:       exp_q.push_back(mk(1'b1, 4'b0010, 3'b011));
                5:       exp_q.push_back(mk(1'b0, 4'b0000, 3'b011));
                default: exp_q.push_back(mk(1'b1, 4'b0000, 3'b010));
            endcase
            apply(v, u, 1'b0, t < 0);
            got = observed();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL bmu_slot t=%0d: got ready=%b dv=%b en=%b, required ready=%b dv=%b en=%b",
                         t, got.ready, got.dv, got.en, e.ready, e.dv, e.en);
            end
        end
    endtask

    task automatic test_div_serialise();
        exp_t e, got;
        for (int t = -1; t <= 35; t++) begin
            if (t < 0)                   exp_q.push_back(mk(1'b0, 4'b0000, 3'b000));
            else if (t == 0 || t == 35)  exp_q.push_back(mk(1'b1, 4'b1000, 3'b100));
            else                         exp_q.push_back(mk(1'b0, 4'b0000, 3'b100));
            apply(t >= 0, U_DIV, 1'b0, t < 0);
            got = observed();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL div_serial t=%0d: got ready=%b dv=%b en=%b, required ready=%b dv=%b en=%b",
                         t, got.ready, got.dv, got.en, e.ready, e.dv, e.en);
            end
        end
    endtask

    task automatic test_bmu_gating();
        exp_t e, got;
        logic v, rdy, en_b;
        int   last_t, last_en;
        for (int reload = 0; reload < 2; reload++) begin
            last_t  = (reload != 0) ? 16 : 11;
            last_en = (reload != 0) ? 14 : 9;
            for (int t = -1; t <= last_t; t++) begin
                v    = (t == 0) || ((reload != 0) && (t == 5));
                rdy  = !((t == 1) || ((reload != 0) && (t == 6)));
                en_b = (t >= 0) && (t <= last_en);
                if (t < 0) exp_q.push_back(mk(1'b0, 4'b0000, 3'b000));
                else       exp_q.push_back(mk(rdy, v ? 4'b0010 : 4'b0000, {2'b00, en_b}));
                apply(v, v ? U_BMU : U_ALU, 1'b0, t < 0);
                got = observed();
                e = exp_q.pop_front();
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL bmu_gate reload=%0d t=%0d: got ready=%b dv=%b en=%b, required ready=%b dv=%b en=%b",
                             reload, t, got.ready, got.dv, got.en, e.ready, e.dv, e.en);
                end
            end
        end
    endtask

    task automatic test_stall();
        exp_t e, got;
        logic v, st;
        for (int t = -1; t <= 8; t++) begin
            st = (t >= 1) && (t <= 3);
            v  = (t == 0) || st || (t >= 7);
            case (t)
                -1:         exp_q.push_back(mk(1'b0, 4'b0000, 3'b000));
                0:          exp_q.push_back(mk(1'b1, 4'b0100, 3'b010));
                1, 2, 3, 7: exp_q.push_back(mk(1'b0, 4'b0000, 3'b010));
                8:          exp_q.push_back(mk(1'b1, 4'b0001, 3'b010));
                default:    exp_q.push_back(mk(1'b1, 4'b0000, 3'b010));
            endcase
            apply(v, (t == 0) ? U_MUL : U_ALU, st, t < 0);
            got = observed();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL stall t=%0d: got ready=%b dv=%b en=%b, required ready=%b dv=%b en=%b",
                         t, got.ready, got.dv, got.en, e.ready, e.dv, e.en);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, got;
        for (int t = -1; t <= 4; t++) begin
            case (t)
                -1, 2:   exp_q.push_back(mk(1'b0, 4'b0000, 3'b000));
                0:       exp_q.push_back(mk(1'b1, 4'b0100, 3'b010));
                1:       exp_q.push_back(mk(1'b1, 4'b0000, 3'b010));
                3:       exp_q.push_back(mk(1'b1, 4'b0000, 3'b000));
                default: exp_q.push_back(mk(1'b1, 4'b0001, 3'b000));
            endcase
            apply((t == 0) || (t == 4), (t == 0) ? U_MUL : U_ALU, 1'b0, (t < 0) || (t == 2));
            got = observed();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset_mid t=%0d: got ready=%b dv=%b en=%b, required ready=%b dv=%b en=%b",
                         t, got.ready, got.dv, got.en, e.ready, e.dv, e.en);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_mul_slot();
        test_bmu_slot();
        test_div_serialise();
        test_bmu_gating();
        test_stall();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: got %0d leftover entries, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
